mult_arbiter: RTL and testbench

- Shares one instance of the team's `mult` (16-bit Q8.8 multiplier; ports clk, reset, in, w, out) between NREQ requesters, e.g. neuron lanes of the dot-product datapath.
- Grants at most one operand pair per cycle using round-robin arbitration, drives the mult operands from registers, and tracks in-flight operations with a tag pipeline.
- Returns each product to its originating requester, tagged with the requester id, in issue order.

---
 rtl/mult_pkg.sv | 17 +
 rtl/mult.sv | 43 ++++
 rtl/rr_arbiter.sv | 34 +++
 rtl/mult_arbiter.sv | 125 ++++++++++++
 tb/tb_mult_arbiter.sv | 352 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mult_pkg.sv
// Shared constants and types for the Q8.8 multiplier and its arbiter.
package mult_pkg;

   localparam int unsigned DW        = 16;
   localparam int unsigned FRAC_BITS = 8;
   localparam int unsigned MULT_LAT  = 1;
   localparam int unsigned ID_W      = 3;

   localparam logic [DW-1:0] Q88_ONE = 16'h0100;

   // In-flight operation marker; id is wide enough for up to 8 requesters.
   typedef struct packed {
      logic            valid;
      logic [ID_W-1:0] id;
   } tag_t;

endpackage

// File: rtl/mult.sv
// Signed Q8.8 multiplier with saturation; one register stage on the product.
module mult
   import mult_pkg::*;
(
   input  logic          clk,
   input  logic          reset,
   input  logic [DW-1:0] in,
   input  logic [DW-1:0] w,
   output logic [DW-1:0] out
);

   localparam logic signed [2*DW-1:0] SAT_MAX = (2*DW)'((1 << (DW-1)) - 1);
   localparam logic signed [2*DW-1:0] SAT_MIN = ~SAT_MAX;

   logic signed [2*DW-1:0] prod_c;
   logic signed [2*DW-1:0] shift_c;
   logic [DW-1:0]          out_d;
   logic [DW-1:0]          out_q;

   // Full-width product, rescale to Q8.8 and clamp into range.
   always_comb begin
      prod_c  = $signed(in) * $signed(w);
      shift_c = prod_c >>> FRAC_BITS;
      out_d   = shift_c[DW-1:0];
      if (shift_c > SAT_MAX) begin
         out_d = SAT_MAX[DW-1:0];
      end else if (shift_c < SAT_MIN) begin
         out_d = SAT_MIN[DW-1:0];
      end
   end

   // Product register.
   always_ff @(posedge clk) begin
      if (!reset) begin
         out_q <= '0;
      end else begin
         out_q <= out_d;
      end
   end

   assign out = out_q;

endmodule

// File: rtl/rr_arbiter.sv
// Rotating-priority picker: first requester at or after ptr, wrapping.
module rr_arbiter #(
   parameter int unsigned NREQ = 4
) (
   input  logic [NREQ-1:0]         req,
   input  logic [$clog2(NREQ)-1:0] ptr,
   input  logic                    en,
   output logic [NREQ-1:0]         grant_c,
   output logic [$clog2(NREQ)-1:0] idx_c,
   output logic                    any_c
);

   localparam int unsigned IDX_W = $clog2(NREQ);

   // Walk the request vector starting at ptr; the first hit wins.
   always_comb begin
      int unsigned cand;
      grant_c = '0;
      idx_c   = '0;
      any_c   = 1'b0;
      cand    = 0;
      if (en) begin
         for (int unsigned off = 0; off < NREQ; off++) begin
            cand = (32'(ptr) + off) % NREQ;
            if (!any_c && req[IDX_W'(cand)]) begin
               any_c                 = 1'b1;
               grant_c[IDX_W'(cand)] = 1'b1;
               idx_c                 = IDX_W'(cand);
            end
         end
      end
   end

endmodule

// File: rtl/mult_arbiter.sv
// Shares one mult between NREQ requesters; products return tagged, in issue order.
module mult_arbiter #(
   parameter int unsigned NREQ     = 4,
   parameter int unsigned DW       = mult_pkg::DW,
   parameter int unsigned MULT_LAT = mult_pkg::MULT_LAT
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    en,
   input  logic [NREQ-1:0]         req_valid,
   output logic [NREQ-1:0]         req_ready,
   input  logic [NREQ*DW-1:0]      req_in,
   input  logic [NREQ*DW-1:0]      req_w,
   output logic [DW-1:0]           mult_in,
   output logic [DW-1:0]           mult_w,
   input  logic [DW-1:0]           mult_out,
   output logic [NREQ-1:0]         rsp_valid,
   output logic [$clog2(NREQ)-1:0] rsp_id,
   output logic [DW-1:0]           rsp_data,
   output logic                    busy
);

   import mult_pkg::*;

   localparam int unsigned IDX_W = $clog2(NREQ);
   localparam int unsigned DEPTH = MULT_LAT + 1;

   logic [NREQ-1:0]  grant_c;
   logic [IDX_W-1:0] gidx_c;
   logic             any_c;

   logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
   logic [DW-1:0]    mult_in_q, mult_in_d;
   logic [DW-1:0]    mult_w_q, mult_w_d;
   tag_t             tag_q [DEPTH];
   tag_t             tag_d [DEPTH];
   logic [NREQ-1:0]  rsp_valid_q, rsp_valid_d;
   logic [IDX_W-1:0] rsp_id_q, rsp_id_d;
   logic [DW-1:0]    rsp_data_q, rsp_data_d;
   logic             busy_q, busy_d;

   // Grants are suppressed while reset is asserted.
   rr_arbiter #(.NREQ(NREQ)) u_rr (
      .req     (req_valid),
      .ptr     (rr_ptr_q),
      .en      (en && reset),
      .grant_c (grant_c),
      .idx_c   (gidx_c),
      .any_c   (any_c)
   );

   assign req_ready = grant_c;

   // Issue, tag shift and response capture.
   always_comb begin
      rr_ptr_d    = rr_ptr_q;
      mult_in_d   = mult_in_q;
      mult_w_d    = mult_w_q;
      rsp_valid_d = '0;
      rsp_id_d    = rsp_id_q;
      rsp_data_d  = rsp_data_q;

      for (int unsigned i = 0; i < NREQ; i++) begin
         if (grant_c[i]) begin
            mult_in_d = req_in[i*DW +: DW];
            mult_w_d  = req_w[i*DW +: DW];
         end
      end
      if (any_c) begin
         rr_ptr_d = (32'(gidx_c) == NREQ - 1) ? '0 : gidx_c + IDX_W'(1);
      end

      tag_d[0].valid = any_c;
      tag_d[0].id    = ID_W'(gidx_c);
      for (int unsigned i = 1; i < DEPTH; i++) begin
         tag_d[i] = tag_q[i-1];
      end

      if (tag_q[DEPTH-1].valid) begin
         rsp_valid_d = NREQ'(1) << tag_q[DEPTH-1].id;
         rsp_id_d    = IDX_W'(tag_q[DEPTH-1].id);
         rsp_data_d  = mult_out;
      end

      busy_d = |rsp_valid_d;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         busy_d = busy_d | tag_d[i].valid;
      end
   end

   // State registers; reset discards any in-flight tags.
   always_ff @(posedge clk) begin
      if (!reset) begin
         rr_ptr_q    <= '0;
         mult_in_q   <= '0;
         mult_w_q    <= '0;
         rsp_valid_q <= '0;
         rsp_id_q    <= '0;
         rsp_data_q  <= '0;
         busy_q      <= 1'b0;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            tag_q[i] <= '0;
         end
      end else begin
         rr_ptr_q    <= rr_ptr_d;
         mult_in_q   <= mult_in_d;
         mult_w_q    <= mult_w_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_id_q    <= rsp_id_d;
         rsp_data_q  <= rsp_data_d;
         busy_q      <= busy_d;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            tag_q[i] <= tag_d[i];
         end
      end
   end

   assign mult_in   = mult_in_q;
   assign mult_w    = mult_w_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_id    = rsp_id_q;
   assign rsp_data  = rsp_data_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_mult_arbiter.sv
// Directed bench for mult_arbiter driving the real Q8.8 mult.
module tb_mult_arbiter;

   localparam int unsigned NREQ = 4;
   localparam int unsigned W    = 16;

   logic              clk   = 1'b0;
   logic              reset = 1'b0;
   logic              en    = 1'b0;
   logic [NREQ-1:0]   req_valid = '0;
   logic [NREQ-1:0]   req_ready;
   logic [NREQ*W-1:0] req_in = '0;
   logic [NREQ*W-1:0] req_w  = '0;
   logic [W-1:0]      mult_in, mult_w, mult_out;
   logic [NREQ-1:0]   rsp_valid;
   logic [1:0]        rsp_id;
   logic [W-1:0]      rsp_data;
   logic              busy;

   always #5 clk = ~clk;

   mult_arbiter #(.NREQ(NREQ), .DW(W), .MULT_LAT(1)) dut (
      .clk       (clk),
      .reset     (reset),
      .en        (en),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_in    (req_in),
      .req_w     (req_w),
      .mult_in   (mult_in),
      .mult_w    (mult_w),
      .mult_out  (mult_out),
      .rsp_valid (rsp_valid),
      .rsp_id    (rsp_id),
      .rsp_data  (rsp_data),
      .busy      (busy)
   );

   mult u_mult (
      .clk   (clk),
      .reset (reset),
      .in    (mult_in),
      .w     (mult_w),
      .out   (mult_out)
   );

   int n_checks = 0;
   int n_errors = 0;
   int cyc      = 0;

   logic [W-1:0] op_a [NREQ][16];
   logic [W-1:0] op_b [NREQ][16];
   int           op_n [NREQ];
   int           op_h [NREQ];

   logic [NREQ-1:0] hs_edge   = '0;
   logic [NREQ-1:0] pend_prev = '0;
   logic            prev_reset = 1'b0;

   int g_id[$], g_cyc[$];
   int r_id[$], r_oh[$], r_data[$], r_cyc[$];
   int e_g[$], e_rid[$], e_rdata[$];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Edge monitor: grant log, handshake capture, requester contract.
   initial begin
      forever begin
         @(posedge clk);
         cyc++;
         for (int i = 0; i < NREQ; i++) begin
            if (req_valid[i] && req_ready[i]) begin
               g_id.push_back(i);
               g_cyc.push_back(cyc);
            end
         end
         if (reset && prev_reset && ((pend_prev & ~req_valid) != '0))
            check("req_drop", 32'(pend_prev & ~req_valid), 32'h0);
         pend_prev  = req_valid & ~req_ready;
         prev_reset = reset;
         hs_edge    = req_valid & req_ready;
      end
   end

   // Response log, sampled mid-cycle.
   initial begin
      forever begin
         @(negedge clk);
         if (rsp_valid != '0) begin
            r_oh.push_back(int'(rsp_valid));
            r_id.push_back(int'(rsp_id));
            r_data.push_back(int'(rsp_data));
            r_cyc.push_back(cyc);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic apply();
      for (int i = 0; i < NREQ; i++) begin
         if (op_h[i] < op_n[i]) begin
            req_valid[i]      = 1'b1;
            req_in[i*W +: W]  = op_a[i][op_h[i]];
            req_w[i*W +: W]   = op_b[i][op_h[i]];
         end else begin
            req_valid[i] = 1'b0;
         end
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      for (int i = 0; i < NREQ; i++) if (hs_edge[i]) op_h[i]++;
      apply();
      #1;
   endtask

   task automatic clear_ops();
      for (int i = 0; i < NREQ; i++) begin
         op_n[i] = 0;
         op_h[i] = 0;
      end
   endtask

   task automatic clear_logs();
      g_id.delete(); g_cyc.delete();
      r_id.delete(); r_oh.delete(); r_data.delete(); r_cyc.delete();
      e_g.delete(); e_rid.delete(); e_rdata.delete();
   endtask

   task automatic push_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
      op_a[i][op_n[i]] = a;
      op_b[i][op_n[i]] = b;
      op_n[i]++;
   endtask

   task automatic expect_rsp(input int id, input int data);
      e_g.push_back(id);
      e_rid.push_back(id);
      e_rdata.push_back(data);
   endtask

   function automatic bit pending();
      pending = 1'b0;
      for (int i = 0; i < NREQ; i++) if (op_h[i] < op_n[i]) pending = 1'b1;
   endfunction

   task automatic run_until_idle(input string tag, input int max);
      int k;
      k = 0;
      while (k < max && (pending() || busy)) begin
         step();
         k++;
      end
      if (k >= max) check({tag, "_timeout"}, 32'd1, 32'd0);
   endtask

   task automatic compare_logs(input string tag, input bit b2b);
      int n;
      check({tag, "_ngrant"}, 32'(g_id.size()), 32'(e_g.size()));
      check({tag, "_nrsp"}, 32'(r_id.size()), 32'(e_rid.size()));
      n = (g_id.size() < e_g.size()) ? g_id.size() : e_g.size();
      for (int i = 0; i < n; i++)
         check($sformatf("%s_grant%0d", tag, i), 32'(g_id[i]), 32'(e_g[i]));
      n = (r_id.size() < e_rid.size()) ? r_id.size() : e_rid.size();
      for (int i = 0; i < n; i++) begin
         check($sformatf("%s_rid%0d", tag, i), 32'(r_id[i]), 32'(e_rid[i]));
         check($sformatf("%s_rdata%0d", tag, i), 32'(r_data[i]), 32'(e_rdata[i]));
         check($sformatf("%s_roh%0d", tag, i), 32'(r_oh[i]), 32'(1 << e_rid[i]));
         if (i < g_cyc.size())
            check($sformatf("%s_lat%0d", tag, i), 32'(r_cyc[i] - g_cyc[i]), 32'd2);
      end
      if (b2b) begin
         for (int i = 1; i < r_cyc.size(); i++)
            check($sformatf("%s_rgap%0d", tag, i), 32'(r_cyc[i] - r_cyc[i-1]), 32'd1);
         for (int i = 1; i < g_cyc.size(); i++)
            check($sformatf("%s_ggap%0d", tag, i), 32'(g_cyc[i] - g_cyc[i-1]), 32'd1);
      end
      clear_logs();
   endtask

   initial begin
      clear_ops();
      clear_logs();

      // 1: reset held with every requester valid
      reset = 1'b0;
      en    = 1'b1;
      for (int i = 0; i < NREQ; i++) push_op(i, 16'h0100, 16'h0100);
      apply();
      repeat (3) begin
         step();
         check("t1_ready", 32'(req_ready), 32'h0);
         check("t1_rsp_valid", 32'(rsp_valid), 32'h0);
         check("t1_rsp_data", 32'(rsp_data), 32'h0);
         check("t1_busy", 32'(busy), 32'h0);
      end
      clear_ops();
      apply();
      step();
      reset = 1'b1;
      step();
      clear_logs();

      // 2: single issue from requester 1
      push_op(1, 16'h0100, 16'h01ff);
      expect_rsp(1, 'h01ff);
      apply();
      #1;
      check("t2_ready", 32'(req_ready), 32'h2);
      step();
      check("t2_rsp_e0", 32'(rsp_valid), 32'h0);
      check("t2_busy_e0", 32'(busy), 32'h1);
      step();
      check("t2_rsp_e1", 32'(rsp_valid), 32'h0);
      step();
      check("t2_rsp_valid", 32'(rsp_valid), 32'h2);
      check("t2_rsp_id", 32'(rsp_id), 32'h1);
      check("t2_rsp_data", 32'(rsp_data), 32'h01ff);
      step();
      check("t2_rsp_e3", 32'(rsp_valid), 32'h0);
      check("t2_busy_e3", 32'(busy), 32'h0);
      compare_logs("t2", 1'b0);

      // 4: partial contention after a grant to requester 2
      clear_ops();
      push_op(2, 16'h0100, 16'h0100);
      expect_rsp(2, 'h0100);
      apply();
      run_until_idle("t4a", 20);
      push_op(0, 16'h1100, 16'h0100);
      push_op(2, 16'h0100, 16'h0100);
      expect_rsp(0, 'h1100);
      expect_rsp(2, 'h0100);
      apply();
      #1;
      check("t4_ready", 32'(req_ready), 32'h1);
      run_until_idle("t4b", 20);
      compare_logs("t4", 1'b0);

      // reset pulse so the pointer restarts at 0
      reset = 1'b0;
      step();
      step();
      reset = 1'b1;
      step();
      clear_logs();

      // 3: full contention, two operations per requester, incl. saturation
      clear_ops();
      push_op(0, 16'h0200, 16'h0300);
      push_op(0, 16'h7f00, 16'h0200);
      push_op(1, 16'h0080, 16'h0080);
      push_op(1, 16'hff00, 16'h0200);
      push_op(2, 16'h0100, 16'h1234);
      push_op(2, 16'h8000, 16'h0200);
      push_op(3, 16'h0180, 16'h0200);
      push_op(3, 16'hfe80, 16'h0100);
      expect_rsp(0, 'h0600);
      expect_rsp(1, 'h0040);
      expect_rsp(2, 'h1234);
      expect_rsp(3, 'h0300);
      expect_rsp(0, 'h7fff);
      expect_rsp(1, 'hfe00);
      expect_rsp(2, 'h8000);
      expect_rsp(3, 'hfe80);
      apply();
      #1;
      check("t3_ready", 32'(req_ready), 32'h1);
      run_until_idle("t3", 40);
      compare_logs("t3", 1'b1);

      // 5: enable gating after a grant to requester 1
      clear_ops();
      push_op(1, 16'h0300, 16'h0100);
      expect_rsp(1, 'h0300);
      apply();
      #1;
      check("t5_ready0", 32'(req_ready), 32'h2);
      step();
      en = 1'b0;
      push_op(0, 16'h0100, 16'h0500);
      push_op(1, 16'h0200, 16'h0200);
      push_op(2, 16'h0040, 16'h0400);
      push_op(3, 16'hff80, 16'h0200);
      apply();
      #1;
      repeat (5) begin
         check("t5_gated", 32'(req_ready), 32'h0);
         step();
      end
      check("t5_busy_low", 32'(busy), 32'h0);
      check("t5_drained", 32'(r_id.size()), 32'd1);
      check("t5_nogrant", 32'(g_id.size()), 32'd1);
      en = 1'b1;
      #1;
      check("t5_ready_resume", 32'(req_ready), 32'h4);
      expect_rsp(2, 'h0100);
      expect_rsp(3, 'hff00);
      expect_rsp(0, 'h0500);
      expect_rsp(1, 'h0400);
      run_until_idle("t5", 30);
      compare_logs("t5", 1'b0);

      // 6: reset one edge after two issues
      clear_ops();
      push_op(0, 16'h0200, 16'h0200);
      push_op(1, 16'h0300, 16'h0100);
      apply();
      #1;
      step();
      step();
      reset = 1'b0;
      step();
      step();
      reset = 1'b1;
      repeat (4) begin
         step();
         check("t6_no_rsp", 32'(rsp_valid), 32'h0);
      end
      check("t6_busy", 32'(busy), 32'h0);
      check("t6_nrsp", 32'(r_id.size()), 32'd0);
      check("t6_issued", 32'(g_id.size()), 32'd2);
      clear_logs();
      clear_ops();
      push_op(1, 16'h0100, 16'h0700);
      push_op(0, 16'h0300, 16'h0300);
      expect_rsp(0, 'h0900);
      expect_rsp(1, 'h0700);
      apply();
      #1;
      check("t6_ready", 32'(req_ready), 32'h1);
      run_until_idle("t6", 20);
      compare_logs("t6", 1'b1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
